// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit types and input-port controller states.
package noc_pkg;

    localparam int FLIT_W  = 34;
    localparam int TYPE_HI = 33;
    localparam int TYPE_LO = 32;
    localparam int YX_HI   = 7;
    localparam int YX_LO   = 0;

    typedef enum logic [1:0] {
        BODY      = 2'b00,
        HEAD      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        XFER,
        REL
    } ipc_state_t;

endpackage

// File: rtl/ipc_fifo.sv
// Synchronous flit FIFO with asynchronous active-high reset; the head entry is
// visible combinationally so the controller can inspect it before popping.
module ipc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0] FULL_COUNT = (ADDR+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR-1:0]  wrPtr_q, wrPtr_d;
    logic [ADDR-1:0]  rdPtr_q, rdPtr_d;
    logic [ADDR:0]    count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/input_port_ctrl.sv
// Router input-port controller: buffers flits, requests the arbiter for each packet
// and streams it to the crossbar. Define IPC_DROP_CNT_EN to add the drop_cnt_o counter.
module input_port_ctrl #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [FLIT_W-1:0] in_flit_i,
    output logic [7:0]        yx_addr_header_o,
    output logic              nhr_write_o,
    input  logic              grant_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [FLIT_W-1:0] out_flit_o,
    output logic              rr_change_order_o,
    output logic              busy_o
`ifdef IPC_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt_o
`endif
);

    import noc_pkg::*;

    ipc_state_t        state_q;
    logic [7:0]        yxAddr_q;
    logic              nhrWrite_q;
    logic              rrChange_q;
    logic [FLIT_W-1:0] headFlit;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPop;
    flit_type_t        headType;
    logic              headIsHeader;
    logic              headIsTail;
    logic              dropFlit;
    logic              outHandshake;

    ipc_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid_i),
        .data_i  (in_flit_i),
        .pop_i   (fifoPop),
        .head_o  (headFlit),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign headType     = flit_type_t'(headFlit[TYPE_HI:TYPE_LO]);
    assign headIsHeader = (headType == HEAD) || (headType == HEAD_TAIL);
    assign headIsTail   = (headType == TAIL) || (headType == HEAD_TAIL);

    // A BODY/TAIL flit at the head while idle has no packet to belong to.
    assign dropFlit     = (state_q == IDLE) && !fifoEmpty && !headIsHeader;
    assign out_valid_o  = (state_q == XFER) && !fifoEmpty && grant_i;
    assign outHandshake = out_valid_o && out_ready_i;
    assign fifoPop      = outHandshake || dropFlit;

    assign in_ready_o        = !fifoFull;
    assign out_flit_o        = headFlit;
    assign yx_addr_header_o  = yxAddr_q;
    assign nhr_write_o       = nhrWrite_q;
    assign rr_change_order_o = rrChange_q;
    assign busy_o            = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            yxAddr_q   <= '0;
            nhrWrite_q <= 1'b0;
            rrChange_q <= 1'b0;
        end else begin
            nhrWrite_q <= 1'b0;
            rrChange_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifoEmpty && headIsHeader) begin
                        yxAddr_q   <= headFlit[YX_HI:YX_LO];
                        nhrWrite_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: state_q <= REQ;
                REQ: begin
                    if (grant_i) state_q <= XFER;
                end
                XFER: begin
                    if (outHandshake && headIsTail) begin
                        rrChange_q <= 1'b1;
                        state_q    <= REL;
                    end
                end
                REL:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IPC_DROP_CNT_EN
    logic [7:0] dropCnt_q;

    assign drop_cnt_o = dropCnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropCnt_q <= '0;
        end else if (dropFlit && (dropCnt_q != 8'hFF)) begin
            dropCnt_q <= dropCnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Scoreboard testbench for input_port_ctrl; forwarded flits are queued on push and
// compared on each crossbar handshake. Checks drop_cnt_o when IPC_DROP_CNT_EN is set.
module tb_input_port_ctrl;

    localparam int FLIT_W = 34;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [FLIT_W-1:0] in_flit_i;
    logic [7:0]        yx_addr_header_o;
    logic              nhr_write_o;
    logic              grant_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [FLIT_W-1:0] out_flit_o;
    logic              rr_change_order_o;
    logic              busy_o;
`ifdef IPC_DROP_CNT_EN
    logic [7:0]        drop_cnt_o;
`endif

    input_port_ctrl #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_flit_i         (in_flit_i),
        .yx_addr_header_o  (yx_addr_header_o),
        .nhr_write_o       (nhr_write_o),
        .grant_i           (grant_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_flit_o        (out_flit_o),
        .rr_change_order_o (rr_change_order_o),
        .busy_o            (busy_o)
`ifdef IPC_DROP_CNT_EN
        ,
        .drop_cnt_o        (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int                assertCount = 0;
    int                failCount   = 0;
    int                cycle       = 0;
    logic              inFwd       = 1'b0;
    logic [FLIT_W-1:0] sbQ[$];
    int                hsLog[$];
    int                nhrCount    = 0;
    int                rrCount     = 0;
    int                lastPushCycle, lastNhrCycle, lastRrCycle;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mkFlit(input logic [1:0] ftype, input logic [31:0] payload);
        return {ftype, payload};
    endfunction

    always @(posedge clk) cycle++;

    // Monitor: the scoreboard is filled on accepted pushes and drained on handshakes.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid_i && in_ready_o) begin
                if (inFwd) sbQ.push_back(in_flit_i);
                lastPushCycle = cycle;
            end
            if (out_valid_o && out_ready_i) begin
                if (sbQ.size() == 0) checkOutput("unexpectedFlit", 64'(1), 64'(0));
                else checkOutput("flitOrder", 64'(out_flit_o), 64'(sbQ.pop_front()));
                hsLog.push_back(cycle);
            end
            if (nhr_write_o) begin
                nhrCount++;
                lastNhrCycle = cycle;
            end
            if (rr_change_order_o) begin
                rrCount++;
                lastRrCycle = cycle;
            end
            if (!grant_i) checkOutput("validNoGrant", 64'(out_valid_o), 64'(0));
        end
    end

    // Entry and exit of every task are at posedge + 1.
    task automatic tryPush(input logic [FLIT_W-1:0] flit, input logic fwd, output logic acc);
        in_valid_i = 1'b1;
        in_flit_i  = flit;
        inFwd      = fwd;
        @(negedge clk);
        acc = in_ready_o;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic applyStimulus(input logic [FLIT_W-1:0] flit, input logic fwd);
        logic acc;
        int   tries = 0;
        acc = 1'b0;
        while (!acc) begin
            tryPush(flit, fwd, acc);
            tries++;
            if (!acc && tries > 200) begin
                checkOutput("pushTimeout", 64'(0), 64'(1));
                break;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 || busy_o) begin
            @(posedge clk); #1;
            n++;
            if (n > maxCycles) begin
                checkOutput("drainTimeout", 64'(0), 64'(1));
                break;
            end
        end
        idleCycles(2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   nhr0, rr0, hs0;
        logic acc;

        reset       = 1'b1;
        in_valid_i  = 1'b0;
        in_flit_i   = '0;
        grant_i     = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rstInReady",  64'(in_ready_o),        64'(1));
        checkOutput("rstOutValid", 64'(out_valid_o),       64'(0));
        checkOutput("rstBusy",     64'(busy_o),            64'(0));
        checkOutput("rstNhr",      64'(nhr_write_o),       64'(0));
        checkOutput("rstRr",       64'(rr_change_order_o), 64'(0));
        checkOutput("rstYx",       64'(yx_addr_header_o),  64'(0));
`ifdef IPC_DROP_CNT_EN
        checkOutput("rstDropCnt",  64'(drop_cnt_o),        64'(0));
`endif

        $display("[TB] single HEAD_TAIL flit, best-case latency");
        grant_i     = 1'b1;
        out_ready_i = 1'b1;
        nhr0 = nhrCount; rr0 = rrCount; hsLog.delete();
        applyStimulus(mkFlit(2'b11, 32'hCAFE_0023), 1'b1);
        waitDrain(50);
        checkOutput("t1NhrLatency", 64'(lastNhrCycle - lastPushCycle), 64'(2));
        checkOutput("t1HsLatency",  64'(hsLog.size() > 0 ? hsLog[0] - lastPushCycle : -1), 64'(4));
        checkOutput("t1RrLatency",  64'(hsLog.size() > 0 ? lastRrCycle - hsLog[0] : -1), 64'(1));
        checkOutput("t1Yx",         64'(yx_addr_header_o), 64'(8'h23));
        checkOutput("t1NhrPulses",  64'(nhrCount - nhr0), 64'(1));
        checkOutput("t1RrPulses",   64'(rrCount - rr0), 64'(1));

        $display("[TB] 4-flit packet with delayed grant");
        grant_i = 1'b0;
        nhr0 = nhrCount; rr0 = rrCount; hsLog.delete();
        applyStimulus(mkFlit(2'b01, 32'h1000_0041), 1'b1);
        applyStimulus(mkFlit(2'b00, 32'h1000_0001), 1'b1);
        applyStimulus(mkFlit(2'b00, 32'h1000_0002), 1'b1);
        applyStimulus(mkFlit(2'b10, 32'h1000_0003), 1'b1);
        idleCycles(5);
        checkOutput("t2BusyInReq",  64'(busy_o), 64'(1));
        checkOutput("t2NoValid",    64'(out_valid_o), 64'(0));
        checkOutput("t2Yx",         64'(yx_addr_header_o), 64'(8'h41));
        grant_i = 1'b1;
        waitDrain(50);
        checkOutput("t2HsCount",    64'(hsLog.size()), 64'(4));
        checkOutput("t2Consecutive", 64'(hsLog.size() == 4 ? hsLog[3] - hsLog[0] : -1), 64'(3));
        checkOutput("t2NhrPulses",  64'(nhrCount - nhr0), 64'(1));
        checkOutput("t2RrPulses",   64'(rrCount - rr0), 64'(1));
        checkOutput("t2YxHeld",     64'(yx_addr_header_o), 64'(8'h41));

        $display("[TB] fill FIFO while grant is low");
        grant_i = 1'b0;
        hsLog.delete();
        applyStimulus(mkFlit(2'b01, 32'h2000_0012), 1'b1);
        applyStimulus(mkFlit(2'b00, 32'h2000_0001), 1'b1);
        applyStimulus(mkFlit(2'b00, 32'h2000_0002), 1'b1);
        applyStimulus(mkFlit(2'b10, 32'h2000_0003), 1'b1);
        checkOutput("t3FullReady", 64'(in_ready_o), 64'(0));
        tryPush(mkFlit(2'b11, 32'h2000_0099), 1'b1, acc);
        checkOutput("t3FullReject", 64'(acc), 64'(0));
        grant_i = 1'b1;
        waitDrain(50);
        checkOutput("t3HsCount",   64'(hsLog.size()), 64'(4));
        checkOutput("t3ReadyBack", 64'(in_ready_o), 64'(1));

        $display("[TB] grant and out_ready toggling");
        nhr0 = nhrCount; rr0 = rrCount; hsLog.delete();
        fork
            begin
                applyStimulus(mkFlit(2'b01, 32'h3000_0034), 1'b1);
                for (int i = 1; i <= 6; i++) applyStimulus(mkFlit(2'b00, 32'h3000_0000 + i), 1'b1);
                applyStimulus(mkFlit(2'b10, 32'h3000_00FF), 1'b1);
            end
            begin
                repeat (40) begin
                    grant_i     = 1'($urandom_range(0, 1));
                    out_ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        grant_i     = 1'b1;
        out_ready_i = 1'b1;
        waitDrain(100);
        checkOutput("t4HsCount",   64'(hsLog.size()), 64'(8));
        checkOutput("t4NhrPulses", 64'(nhrCount - nhr0), 64'(1));
        checkOutput("t4RrPulses",  64'(rrCount - rr0), 64'(1));

        $display("[TB] malformed flits without HEAD");
        nhr0 = nhrCount; hsLog.delete();
        applyStimulus(mkFlit(2'b00, 32'h4000_0011), 1'b0);
        applyStimulus(mkFlit(2'b10, 32'h4000_0022), 1'b0);
        idleCycles(6);
        checkOutput("t5NoNhr",  64'(nhrCount - nhr0), 64'(0));
        checkOutput("t5NoHs",   64'(hsLog.size()), 64'(0));
        checkOutput("t5Idle",   64'(busy_o), 64'(0));
        checkOutput("t5Empty",  64'(in_ready_o), 64'(1));
`ifdef IPC_DROP_CNT_EN
        checkOutput("t5DropCnt", 64'(drop_cnt_o), 64'(2));
`endif

        $display("[TB] reset during XFER");
        out_ready_i = 1'b0;
        hsLog.delete();
        applyStimulus(mkFlit(2'b01, 32'h5000_0037), 1'b1);
        applyStimulus(mkFlit(2'b00, 32'h5000_0001), 1'b1);
        applyStimulus(mkFlit(2'b10, 32'h5000_0002), 1'b1);
        idleCycles(3);
        checkOutput("t6PreValid", 64'(out_valid_o), 64'(1));
        rr0   = rrCount;
        reset = 1'b1;
        #1;
        checkOutput("t6RstValid", 64'(out_valid_o), 64'(0));
        checkOutput("t6RstBusy",  64'(busy_o), 64'(0));
        checkOutput("t6RstYx",    64'(yx_addr_header_o), 64'(0));
        checkOutput("t6RstReady", 64'(in_ready_o), 64'(1));
        checkOutput("t6RstRr",    64'(rr_change_order_o), 64'(0));
        sbQ.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready_i = 1'b1;
        idleCycles(5);
        checkOutput("t6NoRrPulse", 64'(rrCount - rr0), 64'(0));
        checkOutput("t6NoOutput",  64'(hsLog.size()), 64'(0));
        checkOutput("t6StillIdle", 64'(busy_o), 64'(0));
`ifdef IPC_DROP_CNT_EN
        checkOutput("t6DropCntClr", 64'(drop_cnt_o), 64'(0));
`endif
        rr0 = rrCount;
        applyStimulus(mkFlit(2'b11, 32'h6000_005A), 1'b1);
        waitDrain(50);
        checkOutput("t6NewYx",    64'(yx_addr_header_o), 64'(8'h5A));
        checkOutput("t6NewHs",    64'(hsLog.size()), 64'(1));
        checkOutput("t6NewRr",    64'(rrCount - rr0), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
